// File: rtl/axi4_slave_mem_pkg.sv
// Shared response codes and FSM state encodings for the AXI4 slave memory.
package axi4_slave_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

endpackage

// File: rtl/axi4_slave_mem_ram.sv
// Word-wide RAM: one byte-enable write port, one registered read port.
// No reset on the array or the read register so contents survive reset.
module axi4_slave_mem_ram #(
  parameter int WORDS = 1024,
  parameter int IW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Byte-masked write; read register captures pre-write contents on a collision.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 burst slave memory: independent write (AW/W/B) and read (AR/R) FSMs
// sharing a dual-port RAM. All bursts are INCR, full-width, index wraps.
module axi4_slave_mem
  import axi4_slave_mem_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_MEM_WORDS        = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int IW = $clog2(C_MEM_WORDS);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] MEM_BYTES = C_S_AXI_ADDR_WIDTH'(C_MEM_WORDS * 4);

  // Keeps AWREADY/ARREADY low while in reset; they rise on the first edge after release.
  logic alive;
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) alive <= 1'b0;
    else                alive <= 1'b1;
  end

  // ---------------- write channel ----------------
  w_state_t                    w_state, w_next;
  logic [C_S_AXI_ID_WIDTH-1:0] w_id;
  logic [IW-1:0]               w_idx;
  logic [7:0]                  w_len, w_cnt;
  logic                        w_aerr, w_lerr;
  logic                        aw_hs, w_hs;

  assign aw_hs = S_AXI_AWREADY && S_AXI_AWVALID;
  assign w_hs  = S_AXI_WREADY && S_AXI_WVALID;

  // Write state register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) w_state <= W_IDLE;
    else                w_state <= w_next;
  end

  // Write next-state and channel handshake outputs.
  always_comb begin
    w_next        = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = alive;
        if (alive && S_AXI_AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID && (w_cnt == w_len)) w_next = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Burst context: latched on AW, advanced per beat; a WLAST/count mismatch is sticky.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_id   <= '0;
      w_idx  <= '0;
      w_len  <= '0;
      w_cnt  <= '0;
      w_aerr <= 1'b0;
      w_lerr <= 1'b0;
    end else if (aw_hs) begin
      w_id   <= S_AXI_AWID;
      w_idx  <= S_AXI_AWADDR[IW+1:2];
      w_len  <= S_AXI_AWLEN;
      w_cnt  <= '0;
      w_aerr <= (S_AXI_AWADDR >= MEM_BYTES);
      w_lerr <= 1'b0;
    end else if (w_hs) begin
      w_idx <= w_idx + 1'b1;
      w_cnt <= w_cnt + 8'd1;
      if (S_AXI_WLAST != (w_cnt == w_len)) w_lerr <= 1'b1;
    end
  end

  assign S_AXI_BID   = w_id;
  assign S_AXI_BRESP = (w_aerr || w_lerr) ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read channel ----------------
  r_state_t                    r_state, r_next;
  logic [C_S_AXI_ID_WIDTH-1:0] r_id;
  logic [IW-1:0]               r_idx;     // index of the next beat to fetch
  logic [7:0]                  r_len, r_cnt;
  logic                        r_err, r_last_beat;
  logic                        ar_hs, r_hs, ram_re;
  logic [IW-1:0]               ram_raddr;
  logic [31:0]                 ram_rdata;

  assign ar_hs       = S_AXI_ARREADY && S_AXI_ARVALID;
  assign r_hs        = S_AXI_RVALID && S_AXI_RREADY;
  assign r_last_beat = (r_cnt == r_len);

  // Read state register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= R_IDLE;
    else                r_state <= r_next;
  end

  // Read next-state and channel handshake outputs.
  always_comb begin
    r_next        = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    S_AXI_RLAST   = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = alive;
        if (alive && S_AXI_ARVALID) r_next = R_DATA;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        S_AXI_RLAST  = r_last_beat;
        if (S_AXI_RREADY && r_last_beat) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Burst context: the first word is fetched on AR, each later word on the
  // preceding R handshake, so the read register holds steady while stalled.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_id  <= '0;
      r_idx <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (ar_hs) begin
      r_id  <= S_AXI_ARID;
      r_idx <= S_AXI_ARADDR[IW+1:2] + 1'b1;
      r_len <= S_AXI_ARLEN;
      r_cnt <= '0;
      r_err <= (S_AXI_ARADDR >= MEM_BYTES);
    end else if (r_hs && !r_last_beat) begin
      r_idx <= r_idx + 1'b1;
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign ram_re      = ar_hs || (r_hs && !r_last_beat);
  assign ram_raddr   = ar_hs ? S_AXI_ARADDR[IW+1:2] : r_idx;
  assign S_AXI_RID   = r_id;
  assign S_AXI_RDATA = (S_AXI_RVALID && !r_err) ? ram_rdata : '0;
  assign S_AXI_RRESP = (S_AXI_RVALID && r_err) ? RESP_SLVERR : RESP_OKAY;

  axi4_slave_mem_ram #(.WORDS(C_MEM_WORDS), .IW(IW)) u_ram (
    .clk   (S_AXI_ACLK),
    .we    (w_hs && !w_aerr),
    .waddr (w_idx),
    .wstrb (S_AXI_WSTRB),
    .wdata (S_AXI_WDATA),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Self-checking bench for axi4_slave_mem: table of write/read bursts checked
// through B and R scoreboards against a reference memory, plus stall and
// reset-mid-burst sequences.
module tb_axi4_slave_mem;
  import axi4_slave_mem_pkg::*;

  localparam int IDW   = 1;
  localparam int WORDS = 1024;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [IDW-1:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0]     awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]      awlen = '0, arlen = '0;
  logic [3:0]      wstrb = '0;
  logic            awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
  logic            awready, wready, bvalid, arready, rlast, rvalid;
  logic [1:0]      bresp, rresp;

  always #5 clk = ~clk;

  axi4_slave_mem dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [IDW-1:0] id; } r_exp_t;
  typedef struct {
    logic [IDW-1:0] id; logic [31:0] waddr; int wlen; logic [31:0] d0; logic [31:0] dinc;
    logic [3:0] strb; int bad_last; logic [1:0] bresp; logic [31:0] raddr; int rlen;
  } vec_t;

  logic [31:0] model [WORDS];
  b_exp_t      bq[$];
  r_exp_t      rq[$];
  vec_t        vt [8];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({awready, wready, bvalid, bid, bresp, arready, rid, rdata, rresp, rlast, rvalid});
  endfunction

  // One write burst; expected B pushed at drive time, popped at the B handshake.
  task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                          input logic [31:0] d0, input logic [31:0] dinc, input logic [3:0] strb,
                          input int bad_last, input logic [1:0] exp_resp, input int bdelay);
    int n; int lastb; logic oob; logic [9:0] idx; b_exp_t e;
    oob   = (addr >= 32'(WORDS * 4));
    lastb = (bad_last < 0) ? len : bad_last;
    e.id = id; e.resp = exp_resp; bq.push_back(e);
    awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1;
    n = 0; @(negedge clk);
    while (!awready && n < 100) begin n++; @(negedge clk); end
    chk("aw_handshake", 64'(awready), 1);
    @(posedge clk); #1 awvalid = 0;
    idx = addr[11:2];
    for (int b = 0; b <= len; b++) begin
      wdata = d0 + dinc * 32'(b); wstrb = strb; wlast = (b == lastb); wvalid = 1;
      n = 0; @(negedge clk);
      while (!wready && n < 100) begin n++; @(negedge clk); end
      chk("w_handshake", 64'(wready), 1);
      @(posedge clk); #1;
      if (!oob) for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = wdata[8*k +: 8];
      idx++;
    end
    wvalid = 0; wlast = 0;
    if (bdelay > 0) begin
      repeat (bdelay) begin
        @(negedge clk);
        chk("bvalid_held", 64'(bvalid), 1);
        chk("awready_low_in_resp", 64'(awready), 0);
      end
      @(posedge clk); #1;
    end
    bready = 1;
    n = 0; @(negedge clk);
    while (!bvalid && n < 100) begin n++; @(negedge clk); end
    chk("b_handshake", 64'(bvalid), 1);
    e = bq.pop_front();
    chk("bid", 64'(bid), 64'(e.id));
    chk("bresp", 64'(bresp), 64'(e.resp));
    @(posedge clk); #1 bready = 0;
    @(negedge clk);
    chk("awready_after_b", 64'(awready), 1);
    @(posedge clk); #1;
  endtask

  // One read burst; expected beats from the model pushed before AR is driven.
  task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                         input int stall_beat, input int stall_n);
    int n; logic oob; logic [9:0] idx; r_exp_t e; logic [63:0] snap;
    oob = (addr >= 32'(WORDS * 4));
    idx = addr[11:2];
    for (int b = 0; b <= len; b++) begin
      e.data = oob ? 32'h0 : model[idx];
      e.resp = oob ? RESP_SLVERR : RESP_OKAY;
      e.last = (b == len); e.id = id;
      rq.push_back(e); idx++;
    end
    arid = id; araddr = addr; arlen = 8'(len); arvalid = 1;
    n = 0; @(negedge clk);
    while (!arready && n < 100) begin n++; @(negedge clk); end
    chk("ar_handshake", 64'(arready), 1);
    @(posedge clk); #1 arvalid = 0; rready = 1;
    for (int b = 0; b <= len; b++) begin
      if (b == stall_beat) begin
        rready = 0;
        @(negedge clk);
        chk("rvalid_in_stall", 64'(rvalid), 1);
        snap = 64'({rvalid, rdata, rresp, rlast, rid});
        repeat (stall_n - 1) begin
          @(negedge clk);
          chk("r_stall_stable", 64'({rvalid, rdata, rresp, rlast, rid}), snap);
        end
        @(posedge clk); #1 rready = 1;
      end
      n = 0; @(negedge clk);
      while (!rvalid && n < 100) begin n++; @(negedge clk); end
      if (b == 0) chk("ar_to_rvalid_cycles", 64'(n), 0);
      else        chk("r_beat_valid", 64'(rvalid), 1);
      e = rq.pop_front();
      chk("rdata", 64'(rdata), 64'(e.data));
      chk("rresp", 64'(rresp), 64'(e.resp));
      chk("rlast", 64'(rlast), 64'(e.last));
      chk("rid",   64'(rid),   64'(e.id));
      @(posedge clk); #1;
    end
    rready = 0;
    @(negedge clk);
    chk("arready_after_last_r", 64'(arready), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < WORDS; i++) model[i] = 32'h0;
    //        id  waddr      wlen d0            dinc          strb     bad bresp        raddr    rlen
    vt[0] = '{1, 32'h0,    3, 32'h11111111, 32'h11111111, 4'hF,    -1, RESP_OKAY,   32'h0,    3};
    vt[1] = '{0, 32'h40,   0, 32'h12345678, 32'h0,        4'hF,    -1, RESP_OKAY,   32'h40,   0};
    vt[2] = '{1, 32'h40,   0, 32'hAABBCCDD, 32'h0,        4'b0101, -1, RESP_OKAY,   32'h40,   0};
    vt[3] = '{0, 32'h1000, 1, 32'hDEADBEEF, 32'h1,        4'hF,    -1, RESP_SLVERR, 32'h0,    1};
    vt[4] = '{1, 32'h1004, 0, 32'hCAFEF00D, 32'h0,        4'hF,    -1, RESP_SLVERR, 32'h1000, 2};
    vt[5] = '{0, 32'h80,   3, 32'hA0A0A0A0, 32'h01010101, 4'hF,     1, RESP_SLVERR, 32'h80,   3};
    vt[6] = '{1, 32'hFF8,  1, 32'h5555AAAA, 32'h11110000, 4'hF,    -1, RESP_OKAY,   32'hFF8,  3};
    vt[7] = '{0, 32'h100,  7, 32'h01020304, 32'h10203040, 4'hF,    -1, RESP_OKAY,   32'h100,  7};

    // Reset state and ready release.
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 64'h0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("awready_low_before_first_edge", 64'(awready), 0);
    @(negedge clk);
    chk("ready_after_release", 64'({awready, arready}), 64'b11);
    @(posedge clk); #1;

    // Table-driven bursts.
    for (int i = 0; i < 8; i++) begin
      do_write(vt[i].id, vt[i].waddr, vt[i].wlen, vt[i].d0, vt[i].dinc, vt[i].strb,
               vt[i].bad_last, vt[i].bresp, 0);
      do_read(vt[i].id, vt[i].raddr, vt[i].rlen, -1, 0);
    end
    chk("strobe_merge_word", 64'(model[16]), 64'h12BB56DD);

    // Back-pressure on B and R.
    do_write(1, 32'h200, 7, 32'hC0000000, 32'h00000101, 4'hF, -1, RESP_OKAY, 3);
    do_read(1, 32'h200, 7, 3, 5);

    // Reset in the middle of a write burst.
    awid = 1; awaddr = 32'h300; awlen = 8'd3; awvalid = 1;
    n = 0; @(negedge clk);
    while (!awready && n < 100) begin n++; @(negedge clk); end
    chk("aw_handshake_rst", 64'(awready), 1);
    @(posedge clk); #1 awvalid = 0;
    for (int b = 0; b < 2; b++) begin
      wdata = 32'hEE000000 + 32'(b); wstrb = 4'hF; wlast = 0; wvalid = 1;
      n = 0; @(negedge clk);
      while (!wready && n < 100) begin n++; @(negedge clk); end
      chk("w_handshake_rst", 64'(wready), 1);
      @(posedge clk); #1;
    end
    rst_n = 0; wvalid = 0;
    #1 chk("reset_mid_burst_outputs", outs(), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_reset", 64'({awready, wready, bvalid, arready}), 64'b1001);
    @(posedge clk); #1;
    do_read(1, 32'h0, 3, -1, 0);
    do_write(0, 32'h300, 3, 32'h0BADC0DE, 32'h00000010, 4'hF, -1, RESP_OKAY, 0);
    do_read(0, 32'h300, 3, 1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_slave_mem.md
AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem
Interface
REQ-001 SHALL have parameter C_S_AXI_ID_WIDTH, default 1, the width of the AXI ID fields.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, the byte-address width.
REQ-003 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, the data width; only 32 is supported.
REQ-004 SHALL have parameter C_MEM_WORDS, default 1024, the memory depth in words (power of 2).
REQ-005 S_AXI_ACLK  in  1  single clock; all logic on rising edge.
REQ-006 S_AXI_ARESETN  in  1  asynchronous, active-low reset.
REQ-007 S_AXI_AWID  in  ID_WIDTH  write burst ID.
REQ-008 S_AXI_AWADDR  in  ADDR_WIDTH  write start byte address, word-aligned.
REQ-009 S_AXI_AWLEN  in  8  write beats minus 1.
REQ-010 S_AXI_AWVALID  in  1  write address valid.
REQ-011 S_AXI_AWREADY  out  1  write address accepted.
REQ-012 S_AXI_WDATA  in  32  write data.
REQ-013 S_AXI_WSTRB  in  4  byte enables.
REQ-014 S_AXI_WLAST  in  1  last write beat marker.
REQ-015 S_AXI_WVALID  in  1  write data valid.
REQ-016 S_AXI_WREADY  out  1  write data accepted.
REQ-017 S_AXI_BID  out  ID_WIDTH  echoed AWID.
REQ-018 S_AXI_BRESP  out  2  write response (OKAY 00 or SLVERR 10).
REQ-019 S_AXI_BVALID  out  1  response valid.
REQ-020 S_AXI_BREADY  in  1  response accepted.
REQ-021 S_AXI_ARID  in  ID_WIDTH  read burst ID.
REQ-022 S_AXI_ARADDR  in  ADDR_WIDTH  read start byte address, word-aligned.
REQ-023 S_AXI_ARLEN  in  8  read beats minus 1.
REQ-024 S_AXI_ARVALID  in  1  read address valid.
REQ-025 S_AXI_ARREADY  out  1  read address accepted.
REQ-026 S_AXI_RID  out  ID_WIDTH  echoed ARID.
REQ-027 S_AXI_RDATA  out  32  read data.
REQ-028 S_AXI_RRESP  out  2  read response (OKAY or SLVERR).
REQ-029 S_AXI_RLAST  out  1  last read beat.
REQ-030 S_AXI_RVALID  out  1  read data valid.
REQ-031 S_AXI_RREADY  in  1  read data accepted.
Function
REQ-032 SHALL treat every burst as INCR, full-width, with word index ADDR[log2(C_MEM_WORDS)+1:2]; ADDR[1:0] ignored; the index wraps modulo C_MEM_WORDS within a burst.
REQ-033 Write FSM SHALL use states W_IDLE (AWREADY=1), W_DATA (WREADY=1) and W_RESP (BVALID=1): the AW handshake latches ID, index, AWLEN and goes to W_DATA; beat AWLEN goes to W_RESP; the B handshake returns to W_IDLE.
REQ-034 Each W handshake SHALL write only the bytes enabled by WSTRB and increment the index; at most one write burst is outstanding.
REQ-035 BRESP SHALL be SLVERR if AWADDR >= C_MEM_WORDS*4 (all beats accepted, none written) or if WLAST disagrees with the beat count on any beat, and OKAY otherwise.
REQ-036 Read FSM SHALL use states R_IDLE (ARREADY=1) and R_DATA (RVALID=1): the AR handshake latches ID, index, ARLEN; RLAST=1 only on beat ARLEN; the R handshake on the last beat returns to R_IDLE.
REQ-037 The first RVALID SHALL occur the cycle after the AR handshake; RDATA, RRESP, RLAST and RID SHALL hold stable while RVALID=1 and RREADY=0.
REQ-038 A read with ARADDR >= C_MEM_WORDS*4 SHALL return all ARLEN+1 beats with RRESP=SLVERR and RDATA=0.
REQ-039 The read and write channels SHALL run concurrently; a read beat fetched in the same cycle as a write to the same word returns the old data.
REQ-040 AWREADY/ARREADY SHALL re-assert the cycle after the B handshake / the last R handshake, respectively.
Reset
REQ-041 While S_AXI_ARESETN=0: all outputs are 0 (AWREADY/ARREADY are 1 from the first edge after release), both FSMs are in IDLE, and memory contents are preserved; reset mid-burst abandons the burst without issuing a response.
Structure
REQ-042 Package axi4_slave_mem_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants and the write and read state enums.
REQ-043 Sub-module axi4_slave_mem_ram SHALL implement one byte-enable write port and one registered read port.
Verification
REQ-044 Write AW 0x0, len 3, data 0x11111111..0x44444444, WSTRB F -> BRESP 00 with BID echoed; AR 0x0 len 3 -> same data, RLAST on beat 4 only.
REQ-045 Word 0x10 holds 0x12345678; write 0xAABBCCDD with WSTRB 0101 -> readback 0x12BB56DD.
REQ-046 Hold RREADY low 5 cycles mid-burst -> R outputs stable, no beat lost; hold BREADY low 3 cycles -> BVALID held and AWREADY stays 0.
REQ-047 AW/AR at 0x1000 (1024 words) -> BRESP 10 with memory unchanged, RRESP 10 with RDATA 0; WLAST on beat 2 of a len-3 burst -> BRESP 10.
REQ-048 Assert reset during W_DATA -> all outputs at reset values, earlier-written words intact, next burst OKAY.
